// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_pkg
// Brief    : Shared widths and immediate-format encoding for imm_extend_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package imm_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    FMT_B  = 2'd0,
    FMT_CB = 2'd1,
    FMT_D  = 2'd2,
    FMT_I  = 2'd3
  } imm_fmt_t;

endpackage
`default_nettype wire

// File: rtl/imm_extend_unit.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_unit
// Brief    : Combinational immediate extraction/extension and PC-relative add.
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_unit
  import imm_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic [XLEN-1:0]    pc,
  input  logic [1:0]         fmt,
  output logic [XLEN-1:0]    value
);

  logic [XLEN-1:0] w_sextB;
  logic [XLEN-1:0] w_sextCb;
  logic [XLEN-1:0] w_sextD;
  logic [XLEN-1:0] w_zextI;
  logic            w_unused;

  assign w_sextB  = {{(XLEN-26){instr[25]}}, instr[25:0]};
  assign w_sextCb = {{(XLEN-19){instr[23]}}, instr[23:5]};
  assign w_sextD  = {{(XLEN-9){instr[20]}}, instr[20:12]};
  assign w_zextI  = {{(XLEN-12){1'b0}}, instr[21:10]};

  // Opcode bits never contribute to any immediate.
  assign w_unused = &{1'b0, instr[31:26]};

  always_comb begin
    value = '0;
    case (imm_fmt_t'(fmt))
      FMT_B:   value = pc + {w_sextB[XLEN-3:0], 2'b00};
      FMT_CB:  value = pc + {w_sextCb[XLEN-3:0], 2'b00};
      FMT_D:   value = w_sextD;
      FMT_I:   value = w_zextI;
      default: value = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_extend_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_arbiter
// Brief    : Two-port round-robin front end to one immediate/branch-target
//            unit, with a registered valid/ready result tagged by requester.
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_arbiter
  import imm_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [XLEN-1:0]    req0_pc,
  input  logic [INSTR_W-1:0] req0_instr,
  input  logic [1:0]         req0_fmt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [XLEN-1:0]    req1_pc,
  input  logic [INSTR_W-1:0] req1_instr,
  input  logic [1:0]         req1_fmt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_value,
  output logic               out_id
);

  logic               r_prio;
  logic               r_outValid;
  logic [XLEN-1:0]    r_outValue;
  logic               r_outId;

  logic               w_slotFree;
  logic               w_grant0;
  logic               w_grant1;
  logic               w_anyGrant;
  logic [XLEN-1:0]    w_selPc;
  logic [INSTR_W-1:0] w_selInstr;
  logic [1:0]         w_selFmt;
  logic [XLEN-1:0]    w_extValue;

  assign w_slotFree = !r_outValid || out_ready;

  // reset_n gating keeps both readies low while the block is held in reset.
  assign w_grant0   = reset_n && w_slotFree && req0_valid && (!req1_valid || !r_prio);
  assign w_grant1   = reset_n && w_slotFree && req1_valid && (!req0_valid ||  r_prio);
  assign w_anyGrant = w_grant0 || w_grant1;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  assign w_selPc    = w_grant1 ? req1_pc    : req0_pc;
  assign w_selInstr = w_grant1 ? req1_instr : req0_instr;
  assign w_selFmt   = w_grant1 ? req1_fmt   : req0_fmt;

  imm_extend_unit u_ext (
    .instr (w_selInstr),
    .pc    (w_selPc),
    .fmt   (w_selFmt),
    .value (w_extValue)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio <= 1'b0;
    end else if (w_anyGrant) begin
      r_prio <= w_grant0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outValid <= 1'b0;
      r_outValue <= '0;
      r_outId    <= 1'b0;
    end else if (w_slotFree) begin
      r_outValid <= w_anyGrant;
      if (w_anyGrant) begin
        r_outValue <= w_extValue;
        r_outId    <= w_grant1;
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_value = r_outValue;
  assign out_id    = r_outId;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_arbiter
// Brief    : Directed-vector scoreboard bench for imm_extend_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_arbiter;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req0_ready;
  logic [63:0] req0_pc;
  logic [31:0] req0_instr;
  logic [1:0]  req0_fmt;
  logic        req1_valid, req1_ready;
  logic [63:0] req1_pc;
  logic [31:0] req1_instr;
  logic [1:0]  req1_fmt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_value;
  logic        out_id;

  typedef struct {
    logic [63:0] value;
    logic        id;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  imm_extend_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_pc    (req0_pc),
    .req0_instr (req0_instr),
    .req0_fmt   (req0_fmt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_pc    (req1_pc),
    .req1_instr (req1_instr),
    .req1_fmt   (req1_fmt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .out_id     (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] value, input logic id);
    exp_t e;
    e.value = value;
    e.id    = id;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: pops whenever the consumer takes a result.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", out_value, 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check("out_value", out_value, e.value);
          check("out_id", {63'd0, out_id}, {63'd0, e.id});
        end
      end
    end
  endtask

  task automatic send(input bit port, input logic [63:0] pc, input logic [31:0] instr,
                      input logic [1:0] fmt, input logic [63:0] exp);
    bit got;
    got = 1'b0;
    if (port) begin
      req1_valid = 1'b1; req1_pc = pc; req1_instr = instr; req1_fmt = fmt;
    end else begin
      req0_valid = 1'b1; req0_pc = pc; req0_instr = instr; req0_fmt = fmt;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((port ? req1_ready : req0_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("ready_timeout", 64'd0, 64'd1);
    else push(exp, port);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    out_ready   = 1'b1;
    req0_valid  = 1'b1; req0_pc = '0; req0_instr = '0; req0_fmt = 2'd0;
    req1_valid  = 1'b1; req1_pc = '0; req1_instr = '0; req1_fmt = 2'd0;
    fork
      monitor();
    join_none

    // Reset state, with requests pending to show the readies stay low.
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_value", out_value, 64'd0);
    check("rst_out_id", {63'd0, out_id}, 64'd0);
    check("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
    check("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Directed format vectors; unrelated instruction bits set to catch bad slicing.
    send(1'b0, 64'h1000,   32'hA800_3990, 2'd0, 64'h0000_0000_0000_F640);
    send(1'b0, 64'h400000, 32'h03F8_2550, 2'd0, 64'h0000_0000_0020_9540);
    send(1'b1, 64'h2000,   32'hFFFF_FFFF, 2'd1, 64'h0000_0000_0000_1FFC);
    send(1'b1, 64'h0,      32'hFFFF_0FFF, 2'd2, 64'hFFFF_FFFF_FFFF_FFF0);
    send(1'b1, 64'h0,      32'hFFFF_FFFF, 2'd3, 64'h0000_0000_0000_0FFF);
    send(1'b1, 64'h0,      32'h000F_F000, 2'd2, 64'h0000_0000_0000_00FF);
    send(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0001, 2'd0, 64'h0);

    // Back-pressure: port 0 grant moves prio to port 1.
    send(1'b0, 64'h0, 32'h0004_8C00, 2'd3, 64'h123);
    out_ready  = 1'b0;
    req0_valid = 1'b1; req0_pc = 64'h0;   req0_instr = 32'h000F_F000; req0_fmt = 2'd2;
    req1_valid = 1'b1; req1_pc = 64'h100; req1_instr = 32'h0000_0060; req1_fmt = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_out_value", out_value, 64'h123);
      check("bp_out_id", {63'd0, out_id}, 64'd0);
      check("bp_req0_ready", {63'd0, req0_ready}, 64'd0);
      check("bp_req1_ready", {63'd0, req1_ready}, 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_req1_ready", {63'd0, req1_ready}, 64'd1);
    check("bp_release_req0_ready", {63'd0, req0_ready}, 64'd0);
    push(64'h10C, 1'b1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    check("bp_next_req0_ready", {63'd0, req0_ready}, 64'd1);
    push(64'hFF, 1'b0);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Mid-operation reset with a result pending and prio pointing at port 1.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(1'b0, 64'h0, 32'h0000_0400, 2'd3, 64'h1);
    @(negedge clk);
    check("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
    req0_valid = 1'b1; req0_pc = 64'h0;  req0_instr = 32'h0000_5000; req0_fmt = 2'd2;
    req1_valid = 1'b1; req1_pc = 64'h10; req1_instr = 32'h0000_0001; req1_fmt = 2'd0;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_out_value", out_value, 64'd0);
    check("async_rst_out_id", {63'd0, out_id}, 64'd0);
    check("async_rst_req0_ready", {63'd0, req0_ready}, 64'd0);
    check("async_rst_req1_ready", {63'd0, req1_ready}, 64'd0);
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Both ports streaming: grants alternate starting at port 0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_req0_ready", {63'd0, req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
      check("rr_req1_ready", {63'd0, req1_ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
      if (i % 2 == 0) push(64'h5, 1'b0);
      else            push(64'h14, 1'b1);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    check("drain_out_valid", {63'd0, out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
